// File: rtl/mcif_axi_rd_slv.sv
// AXI4 read-channel slave backed by a 1-cycle-latency single-port SRAM.
// Queues AR commands, expands INCR bursts, and returns in-order R beats through a 2-entry skid buffer.
module mcif_axi_rd_slv #(
    parameter int ID_WIDTH   = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int DATA_WIDTH = 256,
    parameter int MEM_AW     = 16,
    parameter int CMD_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   S_AXI_ARID,
    input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [LEN_WIDTH-1:0]  S_AXI_ARLEN,
    input  logic [2:0]            S_AXI_ARSIZE,
    input  logic [1:0]            S_AXI_ARBURST,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [ID_WIDTH-1:0]   S_AXI_RID,
    output logic [DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RLAST,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY,
    output logic                  mem_rd_en,
    output logic [MEM_AW-1:0]     mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    localparam int OFF = $clog2(DATA_WIDTH / 8);
    localparam int CPW = $clog2(CMD_DEPTH);
    localparam logic [CPW:0] PTR_ONE  = (CPW + 1)'(1);
    localparam logic [CPW:0] PTR_FULL = (CPW + 1)'(CMD_DEPTH);

    typedef enum logic {IDLE, BURST} state_t;

    // ---------------- AR command FIFO ----------------
    logic [ID_WIDTH-1:0]   cmd_id_mem   [CMD_DEPTH];
    logic [ADDR_WIDTH-1:0] cmd_addr_mem [CMD_DEPTH];
    logic [LEN_WIDTH-1:0]  cmd_len_mem  [CMD_DEPTH];
    logic [CPW:0]          cmd_wptr_reg, cmd_rptr_reg, cmd_wptr_next, cmd_rptr_next;
    logic                  arready_reg, cmd_push, cmd_pop, cmd_empty;
    logic [ID_WIDTH-1:0]   head_id;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [LEN_WIDTH-1:0]  head_len;
    logic                  head_err;

    assign cmd_push      = S_AXI_ARVALID & arready_reg;
    assign cmd_empty     = (cmd_wptr_reg == cmd_rptr_reg);
    assign cmd_wptr_next = cmd_push ? cmd_wptr_reg + PTR_ONE : cmd_wptr_reg;
    assign cmd_rptr_next = cmd_pop  ? cmd_rptr_reg + PTR_ONE : cmd_rptr_reg;
    assign S_AXI_ARREADY = arready_reg;

    assign head_id   = cmd_id_mem[cmd_rptr_reg[CPW-1:0]];
    assign head_addr = cmd_addr_mem[cmd_rptr_reg[CPW-1:0]];
    assign head_len  = cmd_len_mem[cmd_rptr_reg[CPW-1:0]];
    assign head_err  = ((head_addr >> (MEM_AW + OFF)) != '0);

    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_id_mem[cmd_wptr_reg[CPW-1:0]]   <= S_AXI_ARID;
            cmd_addr_mem[cmd_wptr_reg[CPW-1:0]] <= S_AXI_ARADDR;
            cmd_len_mem[cmd_wptr_reg[CPW-1:0]]  <= S_AXI_ARLEN;
        end
    end

    // ARREADY is a registered !full, so a full FIFO refuses a same-cycle push even while popping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_wptr_reg <= '0;
            cmd_rptr_reg <= '0;
            arready_reg  <= 1'b0;
        end else begin
            cmd_wptr_reg <= cmd_wptr_next;
            cmd_rptr_reg <= cmd_rptr_next;
            arready_reg  <= ((cmd_wptr_next - cmd_rptr_next) != PTR_FULL);
        end
    end

    // ---------------- Burst FSM ----------------
    state_t                state_reg, state_next;
    logic [ID_WIDTH-1:0]   cur_id_reg;
    logic [MEM_AW-1:0]     cur_addr_reg;
    logic [LEN_WIDTH-1:0]  cur_cnt_reg;
    logic                  cur_err_reg;
    logic                  load, issue, can_issue, r_pop;
    logic                  infl_vld_reg, infl_err_reg, infl_last_reg;
    logic [ID_WIDTH-1:0]   infl_id_reg;
    logic [1:0]            buf_cnt_reg;
    logic [2:0]            occupancy;

    // A beat popped this cycle frees its slot, which sustains 1 beat/cycle
    assign r_pop     = S_AXI_RVALID & S_AXI_RREADY;
    assign occupancy = {1'b0, buf_cnt_reg} + {2'b0, infl_vld_reg} - {2'b0, r_pop};
    assign can_issue = (occupancy < 3'd2);

    always_comb begin
        state_next = state_reg;
        cmd_pop    = 1'b0;
        load       = 1'b0;
        issue      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!cmd_empty) begin
                    cmd_pop    = 1'b1;
                    load       = 1'b1;
                    state_next = BURST;
                end
            end
            BURST: begin
                if (can_issue) begin
                    issue = 1'b1;
                    if (cur_cnt_reg == '0) begin
                        if (!cmd_empty) begin
                            cmd_pop = 1'b1;
                            load    = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_rd_en   = issue & ~cur_err_reg;
    assign mem_rd_addr = cur_addr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cur_id_reg    <= '0;
            cur_addr_reg  <= '0;
            cur_cnt_reg   <= '0;
            cur_err_reg   <= 1'b0;
            infl_vld_reg  <= 1'b0;
            infl_id_reg   <= '0;
            infl_err_reg  <= 1'b0;
            infl_last_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            infl_vld_reg  <= issue;
            infl_id_reg   <= cur_id_reg;
            infl_err_reg  <= cur_err_reg;
            infl_last_reg <= (cur_cnt_reg == '0);
            if (load) begin
                cur_id_reg   <= head_id;
                cur_addr_reg <= head_addr[OFF +: MEM_AW];
                cur_cnt_reg  <= head_len;
                cur_err_reg  <= head_err;
            end else if (issue) begin
                cur_addr_reg <= cur_addr_reg + 1'b1;
                cur_cnt_reg  <= cur_cnt_reg - 1'b1;
            end
        end
    end

    // ---------------- 2-entry R output buffer ----------------
    logic [DATA_WIDTH-1:0] buf_data [2];
    logic [ID_WIDTH-1:0]   buf_id   [2];
    logic [1:0]            buf_resp [2];
    logic                  buf_last [2];
    logic                  buf_wptr_reg, buf_rptr_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_buf
            logic [DATA_WIDTH-1:0] data_reg;
            logic [ID_WIDTH-1:0]   id_reg;
            logic [1:0]            resp_reg;
            logic                  last_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_reg <= '0;
                    id_reg   <= '0;
                    resp_reg <= 2'b00;
                    last_reg <= 1'b0;
                end else if (infl_vld_reg && (buf_wptr_reg == 1'(gi))) begin
                    data_reg <= infl_err_reg ? '0 : mem_rd_data;
                    id_reg   <= infl_id_reg;
                    resp_reg <= infl_err_reg ? 2'b10 : 2'b00;
                    last_reg <= infl_last_reg;
                end
            end

            assign buf_data[gi] = data_reg;
            assign buf_id[gi]   = id_reg;
            assign buf_resp[gi] = resp_reg;
            assign buf_last[gi] = last_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_wptr_reg <= 1'b0;
            buf_rptr_reg <= 1'b0;
            buf_cnt_reg  <= 2'd0;
        end else begin
            buf_wptr_reg <= buf_wptr_reg ^ infl_vld_reg;
            buf_rptr_reg <= buf_rptr_reg ^ r_pop;
            buf_cnt_reg  <= buf_cnt_reg + {1'b0, infl_vld_reg} - {1'b0, r_pop};
        end
    end

    assign S_AXI_RVALID = (buf_cnt_reg != 2'd0);
    assign S_AXI_RDATA  = buf_data[buf_rptr_reg];
    assign S_AXI_RID    = buf_id[buf_rptr_reg];
    assign S_AXI_RRESP  = buf_resp[buf_rptr_reg];
    assign S_AXI_RLAST  = buf_last[buf_rptr_reg];

    logic unused_ok;
    assign unused_ok = ^{S_AXI_ARSIZE, S_AXI_ARBURST, head_addr[OFF-1:0]};

endmodule

// File: tb/tb_mcif_axi_rd_slv.sv
// Randomized self-checking bench for mcif_axi_rd_slv with an SRAM model and an expected-beat scoreboard.
module tb_mcif_axi_rd_slv;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   arid = '0;
    logic [31:0]  araddr = '0;
    logic [7:0]   arlen = '0;
    logic [2:0]   arsize = 3'd5;
    logic [1:0]   arburst = 2'b01;
    logic         arvalid = 1'b0;
    logic         arready;
    logic [2:0]   rid;
    logic [255:0] rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;
    logic         mem_rd_en;
    logic [15:0]  mem_rd_addr;
    logic [255:0] mem_rd_data = '0;

    mcif_axi_rd_slv dut (
        .clk(clk), .rst(rst),
        .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
        .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
        .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   id;
        logic [255:0] data;
        logic [1:0]   resp;
        logic         last;
    } beat_t;

    int    checks = 0;
    int    failures = 0;
    beat_t exp_q[$];
    int    pop_cyc[$];
    int    pops = 0;
    int    outst = 0;
    int    ar_acc = 0;
    int    cycle = 0;
    int    rr_mode = 0;
    int    phase = 0;
    bit    mon_en = 0;
    bit    err_window = 0;
    logic [31:0] salt;

    bit           prev_stall = 0;
    logic [255:0] prev_data;
    logic [2:0]   prev_id;
    logic [1:0]   prev_resp;
    logic         prev_last;

    // Deterministic SRAM contents: each 32-bit lane is a hash of word address and lane
    function automatic logic [255:0] mem_word(input logic [15:0] a);
        logic [255:0] w;
        for (int i = 0; i < 8; i++)
            w[i*32 +: 32] = (({16'h0, a} + 32'(i)) * 32'h9E3779B9) ^ salt;
        return w;
    endfunction

    always @(posedge clk) begin
        cycle <= cycle + 1;
        mem_rd_data <= mem_rd_en ? mem_word(mem_rd_addr) : {8{32'($urandom)}};
    end

    initial begin
        rready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            phase++;
            case (rr_mode)
                0: rready = 1'b1;
                1: rready = ((phase % 4) == 0) || ((phase % 4) == 3);
                2: rready = 1'b0;
                default: rready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // R-channel monitor: scoreboard compare, stall stability, outstanding-read bound
    always @(negedge clk) begin
        if (rst || !mon_en) begin
            prev_stall = 0;
        end else begin
            if (mem_rd_en) outst++;
            if (prev_stall) begin
                checks++;
                if (rvalid !== 1'b1 || rdata !== prev_data || rid !== prev_id ||
                    rresp !== prev_resp || rlast !== prev_last) begin
                    failures++;
                    $display("FAIL stall_stable: got rvalid=%b id=%0d resp=%b last=%b, required held id=%0d resp=%b last=%b",
                             rvalid, rid, rresp, rlast, prev_id, prev_resp, prev_last);
                end
            end
            if (rvalid === 1'b1 && rready === 1'b1) begin
                pops++;
                pop_cyc.push_back(cycle);
                if (rresp === 2'b00) outst--;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat: got id=%0d resp=%b last=%b, required no beat", rid, rresp, rlast);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    if (rid !== e.id || rresp !== e.resp || rlast !== e.last || rdata !== e.data) begin
                        failures++;
                        $display("FAIL r_beat: got id=%0d resp=%b last=%b data=%h, required id=%0d resp=%b last=%b data=%h",
                                 rid, rresp, rlast, rdata, e.id, e.resp, e.last, e.data);
                    end
                end
            end
            if (mem_rd_en) begin
                checks++;
                if (outst > 2) begin
                    failures++;
                    $display("FAIL outstanding: got %0d reads outstanding, required at most 2", outst);
                end
            end
            if (err_window) begin
                checks++;
                if (mem_rd_en !== 1'b0) begin
                    failures++;
                    $display("FAIL err_no_read: got mem_rd_en=%b, required 0", mem_rd_en);
                end
            end
            prev_stall = (rvalid === 1'b1) && (rready === 1'b0);
            prev_data  = rdata;
            prev_id    = rid;
            prev_resp  = rresp;
            prev_last  = rlast;
        end
    end

    // Drive one AR (call at posedge+1); on handshake, expand the burst into expected beats
    task automatic send_ar(input logic [2:0] id, input logic [31:0] addr, input logic [7:0] len);
        logic        err;
        logic [15:0] w;
        arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (arready === 1'b1) begin
                @(posedge clk);
                #1;
                arvalid = 1'b0;
                ar_acc++;
                err = (addr >> 21) != 0;
                w   = addr[20:5];
                for (int k = 0; k <= int'(len); k++) begin
                    beat_t b;
                    logic [15:0] a;
                    a = w + 16'(k);
                    b.id = id;
                    b.data = err ? '0 : mem_word(a);
                    b.resp = err ? 2'b10 : 2'b00;
                    b.last = (k == int'(len));
                    exp_q.push_back(b);
                end
                return;
            end
            @(posedge clk);
            #1;
        end
        arvalid = 1'b0;
        checks++;
        failures++;
        $display("FAIL ar_timeout: got no ARREADY for id=%0d, required handshake", id);
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && rvalid === 1'b0) return;
        end
        checks++;
        failures++;
        $display("FAIL drain_timeout: got %0d beats pending, required 0", exp_q.size());
    endtask

    function automatic logic [31:0] rand_addr();
        return {11'd0, 16'($urandom), 5'($urandom)};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({arready, rvalid, rlast, rid, rresp, mem_rd_en} !== 9'b0 || rdata !== '0 || mem_rd_addr !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got arready=%b rvalid=%b rlast=%b rid=%0d rresp=%b en=%b addr=%0d, required all 0",
                     arready, rvalid, rlast, rid, rresp, mem_rd_en, mem_rd_addr);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (arready !== 1'b1 || rvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got arready=%b rvalid=%b, required 1 0", arready, rvalid);
        end
        mon_en = 1;
    endtask

    task automatic test_single_beat();
        rr_mode = 0;
        send_ar(3'd3, 32'h40, 8'd0);
        @(negedge clk);
        checks++;
        if (mem_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL lat_t1: got mem_rd_en=%b, required 0", mem_rd_en);
        end
        @(negedge clk);
        checks++;
        if (mem_rd_en !== 1'b1 || mem_rd_addr !== 16'd2) begin
            failures++;
            $display("FAIL lat_t2: got en=%b addr=%0d, required en=1 addr=2", mem_rd_en, mem_rd_addr);
        end
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b0) begin
            failures++;
            $display("FAIL lat_t3: got rvalid=%b, required 0", rvalid);
        end
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b1) begin
            failures++;
            $display("FAIL lat_t4: got rvalid=%b, required 1", rvalid);
        end
        @(posedge clk);
        #1;
        wait_drain();
    endtask

    task automatic test_burst16();
        int base;
        rr_mode = 0;
        base = pops;
        pop_cyc.delete();
        send_ar(3'd1, 32'h0, 8'd15);
        wait_drain();
        checks++;
        if (pops - base != 16 || pop_cyc.size() != 16 || pop_cyc[pop_cyc.size()-1] - pop_cyc[0] != 15) begin
            failures++;
            $display("FAIL burst16: got %0d beats, required 16 consecutive", pops - base);
        end
    endtask

    task automatic test_backpressure();
        int base;
        rr_mode = 1;
        base = pops;
        send_ar(3'd5, rand_addr(), 8'd7);
        wait_drain();
        checks++;
        if (pops - base != 8) begin
            failures++;
            $display("FAIL backpressure_count: got %0d beats, required 8", pops - base);
        end
    endtask

    task automatic test_fifo_full();
        int  base_pops, base_acc;
        bit  ar_done;
        ar_done   = 0;
        base_pops = pops;
        base_acc  = ar_acc;
        rr_mode   = 2;
        fork
            begin
                for (int i = 0; i < 6; i++) send_ar(3'(i), rand_addr(), 8'd3);
                ar_done = 1;
            end
        join_none
        repeat (40) @(posedge clk);
        @(negedge clk);
        checks++;
        if (arready !== 1'b0 || ar_acc - base_acc != 5) begin
            failures++;
            $display("FAIL fifo_full: got arready=%b accepted=%0d, required 0 and 5", arready, ar_acc - base_acc);
        end
        rr_mode = 0;
        for (int n = 0; n < 500 && !ar_done; n++) @(posedge clk);
        #1;
        wait_drain();
        checks++;
        if (pops - base_pops != 24 || !ar_done) begin
            failures++;
            $display("FAIL fifo_full_beats: got %0d beats done=%0d, required 24 and 1", pops - base_pops, ar_done);
        end
    endtask

    task automatic test_wrap_err();
        int base;
        rr_mode = 3;
        base = pops;
        send_ar(3'd2, 32'd65534 * 32, 8'd3);
        wait_drain();
        checks++;
        if (pops - base != 4) begin
            failures++;
            $display("FAIL wrap_count: got %0d beats, required 4", pops - base);
        end
        base = pops;
        err_window = 1;
        send_ar(3'd6, 32'h8000_0000, 8'd3);
        wait_drain();
        err_window = 0;
        checks++;
        if (pops - base != 4) begin
            failures++;
            $display("FAIL err_count: got %0d beats, required 4", pops - base);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        rr_mode = 0;
        base = pops;
        send_ar(3'd4, rand_addr(), 8'd15);
        for (int n = 0; n < 200 && (pops - base) < 4; n++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (rvalid !== 1'b0 || mem_rd_en !== 1'b0 || arready !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: got rvalid=%b en=%b arready=%b, required 0 0 0", rvalid, mem_rd_en, arready);
        end
        exp_q.delete();
        outst = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (arready !== 1'b1 || rvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_release: got arready=%b rvalid=%b, required 1 0", arready, rvalid);
        end
        base = pops;
        send_ar(3'd7, rand_addr(), 8'd0);
        wait_drain();
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (pops - base != 1) begin
            failures++;
            $display("FAIL reset_mid_stale: got %0d beats, required 1", pops - base);
        end
    endtask

    task automatic test_back_to_back();
        int base, total;
        rr_mode = 0;
        base = pops;
        total = 0;
        pop_cyc.delete();
        for (int i = 0; i < 3; i++) begin
            int len;
            len = $urandom_range(1, 6);
            total += len + 1;
            send_ar(3'(i + 1), rand_addr(), 8'(len));
        end
        wait_drain();
        checks++;
        if (pops - base != total || pop_cyc.size() != total || pop_cyc[pop_cyc.size()-1] - pop_cyc[0] != total - 1) begin
            failures++;
            $display("FAIL back_to_back: got %0d beats (not gapless), required %0d consecutive", pops - base, total);
        end
    endtask

    task automatic test_random();
        int base, total;
        rr_mode = 3;
        base = pops;
        total = 0;
        for (int i = 0; i < 6; i++) begin
            int len;
            logic [31:0] a;
            len = $urandom_range(0, 7);
            a = rand_addr();
            if ($urandom_range(0, 3) == 0) a[31] = 1'b1;
            total += len + 1;
            send_ar(3'($urandom), a, 8'(len));
        end
        wait_drain();
        checks++;
        if (pops - base != total) begin
            failures++;
            $display("FAIL random_count: got %0d beats, required %0d", pops - base, total);
        end
    endtask

    initial begin
        salt = $urandom;
        test_reset();
        test_single_beat();
        test_burst16();
        test_backpressure();
        test_fifo_full();
        test_wrap_err();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got simulation still running, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mcif_axi_rd_slv.md
Name: mcif_axi_rd_slv

Overview:
- AXI4 read-channel responder (slave) backed by a single-port synchronous SRAM with 1-cycle read latency.
- Serves as the memory-side endpoint for the MCIF read master, both in block-level benches and as on-chip scratch memory.
- Queues AR commands, expands each into INCR beats, and returns R data in order with the RID echoed and RLAST on the final beat.
- Absorbs RREADY backpressure without losing SRAM data.

Parameters:
- ID_WIDTH, 3: ARID/RID width.
- ADDR_WIDTH, 32: ARADDR width.
- LEN_WIDTH, 8: ARLEN width; burst length is ARLEN+1 beats.
- DATA_WIDTH, 256: RDATA and SRAM word width; power of two, at least 32.
- MEM_AW, 16: SRAM word-address width; the memory holds 2^MEM_AW words.
- CMD_DEPTH, 4: AR command FIFO depth; power of two, at least 2.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous active-high reset.
- S_AXI_ARID  in  ID_WIDTH  read ID.
- S_AXI_ARADDR  in  ADDR_WIDTH  byte address.
- S_AXI_ARLEN  in  LEN_WIDTH  beats-1.
- S_AXI_ARSIZE  in  3  ignored; full-width beats only.
- S_AXI_ARBURST  in  2  ignored; always treated as INCR.
- S_AXI_ARVALID  in  1  AR valid.
- S_AXI_ARREADY  out  1  AR ready.
- S_AXI_RID  out  ID_WIDTH  ID of the burst being returned.
- S_AXI_RDATA  out  DATA_WIDTH  read data.
- S_AXI_RRESP  out  2  00 OKAY, 10 SLVERR.
- S_AXI_RLAST  out  1  last beat of the burst.
- S_AXI_RVALID  out  1  R valid.
- S_AXI_RREADY  in  1  R ready.
- mem_rd_en  out  1  SRAM read strobe.
- mem_rd_addr  out  MEM_AW  SRAM word address.
- mem_rd_data  in  DATA_WIDTH  SRAM data, valid the cycle after mem_rd_en.

Behaviour:
- Reset values: ARREADY=0 while rst is high and 1 in the first cycle after release (FIFO empty); RVALID=0, RLAST=0, RID=0, RRESP=0, RDATA=0, mem_rd_en=0, mem_rd_addr=0.
- Reset mid-burst drops all queued commands, in-flight reads and buffered beats; the FSM returns to IDLE.

AR command FIFO:
- Depth CMD_DEPTH; each entry holds {id, addr, len}.
- S_AXI_ARREADY = !full; the value is registered and does not depend on ARVALID.
- Push on ARVALID & ARREADY.
- If a push and a pop occur in the same cycle while full, the push is refused (ARREADY was already 0).

Address rules:
- Word address = ARADDR >> log2(DATA_WIDTH/8); low byte-offset bits are discarded.
- A burst is out-of-range if any ARADDR bit above MEM_AW+log2(DATA_WIDTH/8)-1 is nonzero.
- Beat k address = (base+k) mod 2^MEM_AW; wraps silently within range.

Burst FSM:
- IDLE: if the FIFO is non-empty, pop the head, load id, word address and beat counter = len, then go to BURST.
- BURST, issue condition: a beat issues when (buffered beats + in-flight reads) < 2.
- BURST, in-range beat: mem_rd_en=1, mem_rd_addr=current address; increment the address, decrement the counter.
- BURST, out-of-range beat: no SRAM read; a beat tagged SLVERR with RDATA=0 is produced at the same timing as a real read.
- BURST, last beat (counter==0): on issue, if the FIFO is non-empty, pop and load the next command in the same cycle and stay in BURST (no bubble); otherwise go to IDLE.

R output:
- A 2-entry output buffer holds {data, id, resp, last}; mem_rd_data is captured the cycle after mem_rd_en.
- RVALID = buffer non-empty; RID, RDATA, RRESP and RLAST come from the buffer head.
- Pop on RVALID & RREADY; the head must stay stable while RVALID=1 and RREADY=0.
- RLAST=1 only on beat len.

Latency and throughput:
- With an empty pipeline, an AR handshake in cycle T gives mem_rd_en in T+2 and RVALID in T+4.
- With RREADY held high, throughput is 1 beat/cycle, including across back-to-back bursts.

Ordering: responses are strictly in AR acceptance order; IDs are not reordered.

Test Plan:
- Single beat: ARID=3, ARADDR=0x40, ARLEN=0, DATA_WIDTH=256 -> mem_rd_addr=2 at T+2; RVALID at T+4 with RID=3, RLAST=1, RRESP=00, RDATA=mem[2].
- 16-beat burst at ARADDR=0, RREADY=1 -> 16 consecutive RVALID cycles returning mem[0..15]; RLAST only on beat 15.
- Backpressure: 8-beat burst with RREADY toggling 1,0,0,1 -> all 8 beats in order, none lost or duplicated; outputs stable while stalled; never more than 2 reads outstanding.
- FIFO full: hold RREADY=0 and issue 6 ARs of ARLEN=3 with CMD_DEPTH=4 -> ARREADY drops after the FIFO fills; release RREADY -> IDs return in issue order, 24 beats total.
- Wrap and error: ARADDR=(2^16-2)*32, ARLEN=3 -> reads mem[65534], mem[65535], mem[0], mem[1]. ARADDR=0x8000_0000 -> 4 beats, RDATA=0, RRESP=10, no mem_rd_en.
- Reset mid-burst: assert rst during beat 5 of 16 -> RVALID=0 immediately; after release ARREADY=1, and a new single-beat AR completes normally with no stale beats.
